// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM encoding and requester ids for mem_arbiter.
// Optional macro MEM_ARB_TIMEOUT_EN is consumed by mem_arbiter only.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and memory-side signals of mem_arbiter.
// slave = arbiter view, master = environment (requesters + memory) view.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wd;
  logic [DW-1:0] m0_rd;
  logic          m0_ack;
  logic          m0_err;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wd;
  logic [DW-1:0] m1_rd;
  logic          m1_ack;
  logic          m1_err;

  logic          mem_valid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;
  logic          mem_ready;

  logic          busy;
  logic          grant;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wd,
    output m0_rd, m0_ack, m0_err,
    input  m1_req, m1_we, m1_addr, m1_wd,
    output m1_rd, m1_ack, m1_err,
    output mem_valid, mem_we, mem_addr, mem_wd,
    input  mem_rd, mem_ready,
    output busy, grant
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wd,
    input  m0_rd, m0_ack, m0_err,
    output m1_req, m1_we, m1_addr, m1_wd,
    input  m1_rd, m1_ack, m1_err,
    input  mem_valid, mem_we, mem_addr, mem_wd,
    output mem_rd, mem_ready,
    input  busy, grant
  );

endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin pick.
// On a tie the requester that did not win last time is chosen.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = M0;
    unique case (1'b1)
      (req == 2'b11): winner = ~last_grant;
      (req == 2'b10): winner = M1;
      (req == 2'b01): winner = M0;
      default:        winner = M0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between m0 and m1 (IDLE/BUSY/ACK).
// Define MEM_ARB_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES with err.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic          clk,
  input logic          rstn,
  mem_arbiter_if.slave bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_to_chk
    $error("TIMEOUT_CYCLES must fit the 8-bit wait counter");
  end

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          grant_q, grant_d;
  logic          busy_q, busy_d;
  logic          mem_valid_q, mem_valid_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wd_q, mem_wd_d;
  logic [DW-1:0] rd0_q, rd0_d;
  logic [DW-1:0] rd1_q, rd1_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;

  logic          arb_valid;
  logic          arb_win;
  logic          timeout;
  logic [DW-1:0] done_rd;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] wait_q, wait_d;
  logic       err0_q, err0_d;
  logic       err1_q, err1_d;

  assign timeout = (wait_q == 8'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  rr_arbiter2 u_rr (
    .req        ({bus.m1_req, bus.m0_req}),
    .last_grant (last_q),
    .valid      (arb_valid),
    .winner     (arb_win)
  );

  // A timed-out access returns zero data to its requester.
  assign done_rd = bus.mem_ready ? bus.mem_rd : '0;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wd_d    = mem_wd_q;
    rd0_d       = rd0_q;
    rd1_d       = rd1_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    wait_d      = wait_q;
    err0_d      = 1'b0;
    err1_d      = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d     = BUSY;
          grant_d     = arb_win;
          last_d      = arb_win;
          busy_d      = 1'b1;
          mem_valid_d = 1'b1;
          if (arb_win == M1) begin
            mem_we_d   = bus.m1_we;
            mem_addr_d = bus.m1_addr;
            mem_wd_d   = bus.m1_wd;
          end else begin
            mem_we_d   = bus.m0_we;
            mem_addr_d = bus.m0_addr;
            mem_wd_d   = bus.m0_wd;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          wait_d = '0;
`endif
        end
      end
      BUSY: begin
`ifdef MEM_ARB_TIMEOUT_EN
        wait_d = wait_q + 8'd1;
`endif
        if (bus.mem_ready || timeout) begin
          state_d     = ACK;
          mem_valid_d = 1'b0;
          mem_we_d    = 1'b0;
          if (grant_q == M1) begin
            rd1_d  = done_rd;
            ack1_d = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
            err1_d = ~bus.mem_ready;
`endif
          end else begin
            rd0_d  = done_rd;
            ack0_d = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
            err0_d = ~bus.mem_ready;
`endif
          end
        end
      end
      ACK: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d     = IDLE;
        busy_d      = 1'b0;
        mem_valid_d = 1'b0;
        mem_we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      last_q      <= M1;
      grant_q     <= M0;
      busy_q      <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wd_q    <= '0;
      rd0_q       <= '0;
      rd1_q       <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_q      <= '0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wd_q    <= mem_wd_d;
      rd0_q       <= rd0_d;
      rd1_q       <= rd1_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_q      <= wait_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
`endif
    end
  end

  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wd    = mem_wd_q;
  assign bus.m0_rd     = rd0_q;
  assign bus.m1_rd     = rd1_q;
  assign bus.m0_ack    = ack0_q;
  assign bus.m1_ack    = ack1_q;
  assign bus.busy      = busy_q;
  assign bus.grant     = grant_q;

`ifdef MEM_ARB_TIMEOUT_EN
  assign bus.m0_err = err0_q;
  assign bus.m1_err = err1_q;
`else
  assign bus.m0_err = 1'b0;
  assign bus.m1_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed cases plus random traffic checked against
// a transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(
    .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit          rq   [2];
  bit          rwe  [2];
  logic [31:0] radr [2];
  logic [31:0] rwd  [2];
  bit          mrdy;
  logic [31:0] mrdat;

  // own = requester currently holding the memory (-1: none)
  int          own;
  bit          acking;
  bit          aerr;
  bit          last;
  int          waits;
  bit          cur_we;
  logic [31:0] cur_addr;
  logic [31:0] cur_wd;
  logic [31:0] e_rd [2];
  int          m_acks [2];
  int          d_acks [2];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    bus.m0_req    = rq[0];
    bus.m0_we     = rwe[0];
    bus.m0_addr   = radr[0];
    bus.m0_wd     = rwd[0];
    bus.m1_req    = rq[1];
    bus.m1_we     = rwe[1];
    bus.m1_addr   = radr[1];
    bus.m1_wd     = rwd[1];
    bus.mem_ready = mrdy;
    bus.mem_rd    = mrdat;
  endtask

  task automatic model_reset();
    own      = -1;
    acking   = 1'b0;
    aerr     = 1'b0;
    last     = 1'b1;
    waits    = 0;
    cur_we   = 1'b0;
    cur_addr = '0;
    cur_wd   = '0;
    e_rd[0]  = '0;
    e_rd[1]  = '0;
  endtask

  // One rising edge worth of arbiter behaviour, at transaction level.
  task automatic model_edge();
    if (acking) begin
      acking = 1'b0;
      aerr   = 1'b0;
      own    = -1;
    end else if (own >= 0) begin
      if (mrdy) begin
        acking    = 1'b1;
        e_rd[own] = mrdat;
        m_acks[own]++;
      end else begin
        waits++;
`ifdef MEM_ARB_TIMEOUT_EN
        if (waits == TO) begin
          acking    = 1'b1;
          aerr      = 1'b1;
          e_rd[own] = '0;
          m_acks[own]++;
        end
`endif
      end
    end else if (rq[0] || rq[1]) begin
      if (rq[0] && rq[1]) own = last ? 0 : 1;
      else                own = rq[1] ? 1 : 0;
      last     = (own == 1);
      cur_we   = rwe[own];
      cur_addr = radr[own];
      cur_wd   = rwd[own];
      waits    = 0;
    end
  endtask

  task automatic compare();
    bit v;
    v = (own >= 0) && !acking;
    chk("mem_valid", bus.mem_valid, v);
    chk("mem_we", bus.mem_we, v && cur_we);
    if (v) begin
      chk("mem_addr", bus.mem_addr, cur_addr);
      chk("mem_wd", bus.mem_wd, cur_wd);
    end
    chk("busy", bus.busy, own >= 0);
    if (own >= 0) chk("grant", bus.grant, own == 1);
    chk("m0_ack", bus.m0_ack, acking && own == 0);
    chk("m1_ack", bus.m1_ack, acking && own == 1);
    chk("m0_err", bus.m0_err, acking && own == 0 && aerr);
    chk("m1_err", bus.m1_err, acking && own == 1 && aerr);
    chk("m0_rd", bus.m0_rd, e_rd[0]);
    chk("m1_rd", bus.m1_rd, e_rd[1]);
  endtask

  task automatic step();
    @(negedge clk);
    model_edge();
    compare();
    if (bus.m0_ack === 1'b1) d_acks[0]++;
    if (bus.m1_ack === 1'b1) d_acks[1]++;
  endtask

  task automatic quiet();
    rq[0] = 1'b0;
    rq[1] = 1'b0;
    mrdy  = 1'b0;
    drive();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, bus.mem_valid, 0);
    chk({tag, "_we"}, bus.mem_we, 0);
    chk({tag, "_addr"}, bus.mem_addr, 0);
    chk({tag, "_wd"}, bus.mem_wd, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_grant"}, bus.grant, 0);
    chk({tag, "_acks"}, {bus.m0_ack, bus.m1_ack}, 0);
    chk({tag, "_rd0"}, bus.m0_rd, 0);
    chk({tag, "_rd1"}, bus.m1_rd, 0);
  endtask

  task automatic do_reset();
    quiet();
    rstn = 1'b0;
    model_reset();
    #1;
    check_zero("rst");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic new_txn(input int i);
    rq[i]   = 1'b1;
    rwe[i]  = 1'($urandom_range(0, 1));
    radr[i] = $urandom;
    rwd[i]  = $urandom;
  endtask

  int k;
  int bc;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rq[i] = 0; rwe[i] = 0; radr[i] = 0; rwd[i] = 0;
      m_acks[i] = 0; d_acks[i] = 0;
    end
    mrdy  = 1'b0;
    mrdat = '0;
    drive();
    do_reset();
    step();
    chk("idle_valid", bus.mem_valid, 0);

    // m0 read of 0x100, ready in the first BUSY cycle
    rq[0] = 1; rwe[0] = 0; radr[0] = 32'h100; rwd[0] = 0;
    drive();
    step();
    chk("t1_valid", bus.mem_valid, 1);
    chk("t1_ack_early", bus.m0_ack, 0);
    mrdy = 1; mrdat = 32'hDEADBEEF;
    drive();
    step();
    chk("t1_ack", bus.m0_ack, 1);
    chk("t1_rd", bus.m0_rd, 32'hDEADBEEF);
    chk("t1_valid_off", bus.mem_valid, 0);
    quiet();
    step();
    chk("t1_ack_once", bus.m0_ack, 0);

    // Simultaneous requests held: grants alternate 0,1,0,1
    do_reset();
    rq[0] = 1; rwe[0] = 0; radr[0] = 32'h10;
    rq[1] = 1; rwe[1] = 1; radr[1] = 32'h14;
    rwd[1] = 32'h1234;
    drive();
    k = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      step();
      if (acking) begin
        chk("rr_grant", bus.grant, k % 2);
        chk("rr_ack0", bus.m0_ack, (k % 2) == 0);
        k++;
      end
      mrdy  = (own >= 0) && !acking;
      mrdat = $urandom;
      drive();
    end
    chk("rr_count", k, 4);
    quiet();
    step();

    // m1 write 0x55AA to 0x20 with 3 wait cycles
    rq[1] = 1; rwe[1] = 1; radr[1] = 32'h20;
    rwd[1] = 32'h55AA;
    drive();
    for (int c = 0; c < 4; c++) begin
      step();
      chk("t3_we", bus.mem_we, 1);
      chk("t3_addr", bus.mem_addr, 32'h20);
      chk("t3_wd", bus.mem_wd, 32'h55AA);
      chk("t3_no_ack", bus.m1_ack | bus.m0_ack, 0);
      mrdy  = (c == 3);
      mrdat = 32'hCAFE0001;
      drive();
    end
    step();
    chk("t3_ack", bus.m1_ack, 1);
    chk("t3_m0", bus.m0_ack, 0);
    chk("t3_rd", bus.m1_rd, 32'hCAFE0001);
    quiet();
    step();

    // Asynchronous reset while BUSY
    rq[0] = 1; rwe[0] = 1; radr[0] = 32'h40;
    rwd[0] = 32'h77;
    drive();
    step();
    chk("t4_busy", bus.busy, 1);
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    check_zero("t4");
    repeat (2) @(negedge clk);
    chk("t4_no_ack", bus.m0_ack, 0);
    rstn = 1'b1;
    k = 0;
    for (int c = 0; c < 10 && k == 0; c++) begin
      step();
      if (bus.m0_ack === 1'b1) k = 1;
      mrdy  = (own >= 0) && !acking;
      mrdat = 32'hA5A5;
      drive();
    end
    chk("t4_reack", k, 1);
    chk("t4_rd", bus.m0_rd, 32'hA5A5);
    quiet();
    step();

`ifdef MEM_ARB_TIMEOUT_EN
    // mem_ready stuck low: err+ack after 16 BUSY cycles
    rq[0] = 1; rwe[0] = 0; radr[0] = 32'h80;
    drive();
    step();
    bc = 1;
    for (int c = 0; c < 40; c++) begin
      step();
      bc++;
      if (bus.m0_ack === 1'b1) break;
    end
    chk("to_cycle", bc, TO + 1);
    chk("to_err", bus.m0_err, 1);
    chk("to_rd", bus.m0_rd, 0);
    quiet();
    step();
    // mem_ready in BUSY cycle 16 beats the timeout
    rq[0] = 1;
    drive();
    step();
    bc = 1;
    for (int c = 0; c < 40; c++) begin
      mrdy  = (bc == TO);
      mrdat = 32'hBEEF0016;
      drive();
      step();
      bc++;
      if (bus.m0_ack === 1'b1) break;
    end
    chk("to16_cycle", bc, TO + 1);
    chk("to16_err", bus.m0_err, 0);
    chk("to16_rd", bus.m0_rd, 32'hBEEF0016);
    quiet();
    step();
`endif

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 2; i++) begin
      m_acks[i] = 0;
      d_acks[i] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        if (rq[i] && acking && own == i) begin
          if ($urandom_range(0, 1) == 1) new_txn(i);
          else rq[i] = 1'b0;
        end else if (!rq[i] && $urandom_range(0, 2) == 0) begin
          new_txn(i);
        end
      end
      mrdy  = (own >= 0) && !acking &&
              ($urandom_range(0, 2) == 0);
      mrdat = $urandom;
      drive();
    end
    chk("acks_m0", d_acks[0], m_acks[0]);
    chk("acks_m1", d_acks[1], m_acks[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
